// File: rtl/x_delay_line_pkg.sv
// Shared types and helpers for the delay-line thermometer encoder.
package x_delay_line_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSum   = 2'd1,
        StFin   = 2'd2,
        StValid = 2'd3
    } state_e;

    localparam int unsigned GroupBits   = 8;
    localparam int unsigned GroupCountW = 4;

    // Width needed to hold a tap count from 0 up to and including n_taps.
    function automatic int unsigned tap_count_width(input int unsigned n_taps);
        return $clog2(n_taps + 1);
    endfunction

endpackage

// File: rtl/x_popcount8.sv
// Combinational ones-count of one eight-tap group.
module x_popcount8
    import x_delay_line_pkg::*;
(
    input  logic [GroupBits-1:0]   bits,
    output logic [GroupCountW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < GroupBits; i++) begin
            count = count + GroupCountW'(bits[i]);
        end
    end

endmodule

// File: rtl/x_delay_line_encoder.sv
// Captures a delay-line snapshot and encodes it as a ones-count over a
// three-cycle pipeline (capture, group popcount, final sum) with a handshake.
module x_delay_line_encoder
    import x_delay_line_pkg::*;
#(
    parameter int unsigned N_TAPS = 64,
    parameter int unsigned W      = tap_count_width(N_TAPS)
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic [N_TAPS-1:0] i_q,
    input  logic              i_sample,
    input  logic              i_pol,
    input  logic              i_ready,
    output logic [W-1:0]      o_code,
    output logic              o_valid,
    output logic              o_bubble,
    output logic              o_ovf,
    output logic              o_busy,
    output logic              o_drop
);

    localparam int unsigned NGroups = N_TAPS / GroupBits;

    state_e state_q, state_d;

    logic [N_TAPS-1:0]                      norm;
    logic [N_TAPS-1:0]                      cap_q;
    logic [NGroups-1:0][GroupCountW-1:0]    grp_cnt;
    logic [NGroups-1:0][GroupCountW-1:0]    grp_q;
    logic                                   bubble_pre_q;
    logic                                   bubble_pre;
    logic [W-1:0]                           code_sum;

    logic [W-1:0] code_q;
    logic         valid_q, bubble_q, ovf_q, busy_q, drop_q;

    logic cap_en, sum_en, fin_en, ack;

    // Undo the per-cell inversion so every reached tap reads 1.
    always_comb begin
        norm = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            norm[k] = i_q[k] ^ i_pol ^ (k[0] == 1'b0);
        end
    end

    for (genvar g = 0; g < NGroups; g++) begin : g_pc
        x_popcount8 u_popcount8 (
            .bits  (cap_q[g*GroupBits +: GroupBits]),
            .count (grp_cnt[g])
        );
    end

    // A 1 sitting directly above a 0 breaks the thermometer shape.
    assign bubble_pre = |(cap_q[N_TAPS-1:1] & ~cap_q[N_TAPS-2:0]);

    always_comb begin
        code_sum = '0;
        for (int g = 0; g < NGroups; g++) begin
            code_sum = code_sum + W'(grp_q[g]);
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_sample) state_d = StSum;
            StSum:   state_d = StFin;
            StFin:   state_d = StValid;
            StValid: if (i_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath enables
    always_comb begin
        cap_en = (state_q == StIdle) && i_sample;
        sum_en = (state_q == StSum);
        fin_en = (state_q == StFin);
        ack    = (state_q == StValid) && valid_q && i_ready;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cap_q        <= '0;
            grp_q        <= '0;
            bubble_pre_q <= 1'b0;
            code_q       <= '0;
            bubble_q     <= 1'b0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            if (cap_en) begin
                cap_q <= norm;
            end
            if (sum_en) begin
                grp_q        <= grp_cnt;
                bubble_pre_q <= bubble_pre;
            end
            if (fin_en) begin
                code_q   <= code_sum;
                bubble_q <= bubble_pre_q;
                ovf_q    <= (code_sum == W'(N_TAPS));
                valid_q  <= 1'b1;
            end else if (ack) begin
                valid_q <= 1'b0;
            end
            busy_q <= (state_d != StIdle);
            drop_q <= i_sample && (state_q != StIdle);
        end
    end

    assign o_code   = code_q;
    assign o_valid  = valid_q;
    assign o_bubble = bubble_q;
    assign o_ovf    = ovf_q;
    assign o_busy   = busy_q;
    assign o_drop   = drop_q;

endmodule

// File: tb/tb_x_delay_line_encoder.sv
// Scoreboard bench for x_delay_line_encoder with N_TAPS=64.
module tb_x_delay_line_encoder;

    localparam int unsigned N_TAPS = 64;
    localparam int unsigned W      = 7;
    localparam logic [63:0] EVEN_MASK = 64'h5555_5555_5555_5555;

    logic              clk = 1'b0;
    logic              nrst;
    logic [N_TAPS-1:0] q;
    logic              sample, pol, ready;
    logic [W-1:0]      code;
    logic              valid, bubble, ovf, busy, drop;

    typedef struct packed {
        logic [W-1:0] code;
        logic         bubble;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    x_delay_line_encoder #(.N_TAPS(N_TAPS)) dut (
        .i_clk    (clk),
        .i_nrst   (nrst),
        .i_q      (q),
        .i_sample (sample),
        .i_pol    (pol),
        .i_ready  (ready),
        .o_code   (code),
        .o_valid  (valid),
        .o_bubble (bubble),
        .o_ovf    (ovf),
        .o_busy   (busy),
        .o_drop   (drop)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result from a normalised word: clean iff it equals 2^count-1.
    function automatic exp_t model(input logic [63:0] norm);
        int   c = 0;
        exp_t e;
        for (int k = 0; k < 64; k++) c += int'(norm[k]);
        e.code   = W'(c);
        e.bubble = (norm != ((64'd1 << c) - 64'd1));
        e.ovf    = (c == 64);
        return e;
    endfunction

    function automatic logic [63:0] raw_of(input logic [63:0] norm, input logic p);
        return norm ^ EVEN_MASK ^ {64{p}};
    endfunction

    task automatic start(input string tag, input logic [63:0] raw, input logic p,
                         input logic [63:0] norm);
        @(negedge clk);
        q      = raw;
        pol    = p;
        sample = 1'b1;
        sb.push_back(model(norm));
        @(negedge clk);
        sample = 1'b0;
        q      = {$urandom, $urandom};
        check_eq({tag, "_busy_e0"}, 64'(busy), 64'd1);
        check_eq({tag, "_valid_e0"}, 64'(valid), 64'd0);
    endtask

    task automatic finish_result(input string tag, input int hold);
        exp_t e;
        int   drops = 0;
        @(negedge clk);
        check_eq({tag, "_valid_e1"}, 64'(valid), 64'd0);
        @(negedge clk);
        check_eq({tag, "_valid_e2"}, 64'(valid), 64'd1);
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check_eq({tag, "_code"}, 64'(code), 64'(e.code));
        check_eq({tag, "_bubble"}, 64'(bubble), 64'(e.bubble));
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                sample = (i == 1);
                @(negedge clk);
                sample = 1'b0;
                if (drop) drops++;
                check_eq({tag, "_hold_valid"}, 64'(valid), 64'd1);
                check_eq({tag, "_hold_code"}, 64'(code), 64'(e.code));
                check_eq({tag, "_hold_ovf"}, 64'(ovf), 64'(e.ovf));
            end
            check_eq({tag, "_drop_count"}, 64'(drops), 64'd1);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_eq({tag, "_valid_ack"}, 64'(valid), 64'd0);
        check_eq({tag, "_busy_ack"}, 64'(busy), 64'd0);
        check_eq({tag, "_code_kept"}, 64'(code), 64'(e.code));
    endtask

    task automatic run_case(input string tag, input logic [63:0] norm, input logic p,
                            input int hold);
        start(tag, raw_of(norm, p), p, norm);
        finish_result(tag, hold);
    endtask

    initial begin
        int vcnt;
        int dcnt;
        exp_t e;
        nrst   = 1'b0;
        sample = 1'b0;
        pol    = 1'b0;
        ready  = 1'b0;
        q      = '0;
        #3;
        check_eq("rst_code", 64'(code), 64'd0);
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_bubble", 64'(bubble), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_drop", 64'(drop), 64'd0);
        @(negedge clk);
        nrst = 1'b1;

        run_case("ten_pol0", 64'h3FF, 1'b0, 0);
        // Same raw word with the opposite launch polarity.
        start("ten_pol1", raw_of(64'h3FF, 1'b0), 1'b1, ~64'h3FF);
        finish_result("ten_pol1", 0);
        run_case("bubble", 64'hF7, 1'b0, 0);
        run_case("zeros", 64'h0, 1'b1, 0);
        run_case("ones", {64{1'b1}}, 1'b0, 5);

        // Reset in SUM aborts the measurement.
        start("rst_mid", raw_of(64'hFFFF, 1'b0), 1'b0, 64'hFFFF);
        nrst = 1'b0;
        #1;
        check_eq("rstmid_code", 64'(code), 64'd0);
        check_eq("rstmid_valid", 64'(valid), 64'd0);
        check_eq("rstmid_busy", 64'(busy), 64'd0);
        check_eq("rstmid_ovf", 64'(ovf), 64'd0);
        check_eq("rstmid_drop", 64'(drop), 64'd0);
        sb.delete(sb.size() - 1);
        @(negedge clk);
        check_eq("rstmid_hold_valid", 64'(valid), 64'd0);
        nrst = 1'b1;
        run_case("after_rst", 64'h7FFF, 1'b1, 0);

        // Back-to-back sampling with i_ready held high.
        vcnt   = 0;
        dcnt   = 0;
        ready  = 1'b1;
        pol    = 1'b0;
        q      = raw_of(64'h3F, 1'b0);
        sample = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) sb.push_back(model(64'h3F));
            @(negedge clk);
            if (drop) dcnt++;
            if (valid) begin
                vcnt++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("tput_code", 64'(code), 64'(e.code));
                end else begin
                    check_eq("tput_sb", 64'(sb.size()), 64'd1);
                end
            end
        end
        sample = 1'b0;
        ready  = 1'b0;
        check_eq("tput_results", 64'(vcnt), 64'd4);
        check_eq("tput_drops", 64'(dcnt), 64'd12);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
